// File: rtl/bip_control_unit.sv
// BIP I fetch/decode control: program counter, IDLE/RUN/HALT sequencing,
// combinational instruction decode into datapath strobes, and a RUN-cycle counter.
module bip_control_unit #(
  parameter int PC_WIDTH     = 11,
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_WIDTH = 5,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  output logic [PC_WIDTH-1:0]    addr_program,
  output logic [PC_WIDTH-1:0]    o_operand,
  output logic [1:0]             o_sel_a,
  output logic                   o_sel_b,
  output logic                   o_op,
  output logic                   o_wr_acc,
  output logic                   o_wr_ram,
  output logic                   o_rd_ram,
  output logic                   o_running,
  output logic                   o_halted,
  output logic [COUNT_WIDTH-1:0] o_cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic                    w_is_hlt;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign w_opcode  = i_instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign w_is_hlt  = (w_opcode == OP_HLT);
  assign o_operand = i_instruction[PC_WIDTH-1:0];

  assign addr_program  = r_pc;
  assign o_cycle_count = r_count;
  assign o_running     = (r_state == S_RUN);
  assign o_halted      = (r_state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_RUN) begin
        r_count <= sat_inc(r_count);
        // HLT freezes the PC on its own address so the debugger sees where it stopped
        if (!w_is_hlt) r_pc <= r_pc + PC_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_sel_a      = 2'b00;
    o_sel_b      = 1'b0;
    o_op         = 1'b0;
    o_wr_acc     = 1'b0;
    o_wr_ram     = 1'b0;
    o_rd_ram     = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next_state = S_RUN;
      S_RUN: begin
        if (w_is_hlt) w_next_state = S_HALT;
        case (w_opcode)
          OP_STO:  o_wr_ram = 1'b1;
          OP_LD: begin
            o_rd_ram = 1'b1;
            o_wr_acc = 1'b1;
          end
          OP_LDI: begin
            o_wr_acc = 1'b1;
            o_sel_a  = 2'b01;
          end
          OP_ADD, OP_SUB: begin
            o_rd_ram = 1'b1;
            o_wr_acc = 1'b1;
            o_sel_a  = 2'b10;
            o_op     = (w_opcode == OP_SUB);
          end
          OP_ADDI, OP_SUBI: begin
            o_wr_acc = 1'b1;
            o_sel_a  = 2'b10;
            o_sel_b  = 1'b1;
            o_op     = (w_opcode == OP_SUBI);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: directed program scenarios plus randomized programs,
// checked every cycle against a behavioural IDLE/RUN/HALT model.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [15:0] i_instruction;
  logic [10:0] addr_program;
  logic [10:0] o_operand;
  logic [1:0]  o_sel_a;
  logic        o_sel_b, o_op, o_wr_acc, o_wr_ram, o_rd_ram, o_running, o_halted;
  logic [31:0] o_cycle_count;

  logic [15:0] mem [0:2047];
  assign i_instruction = mem[addr_program];

  bip_control_unit dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_instruction(i_instruction),
    .addr_program(addr_program), .o_operand(o_operand), .o_sel_a(o_sel_a),
    .o_sel_b(o_sel_b), .o_op(o_op), .o_wr_acc(o_wr_acc), .o_wr_ram(o_wr_ram),
    .o_rd_ram(o_rd_ram), .o_running(o_running), .o_halted(o_halted),
    .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 = idle, 1 = run, 2 = halt
  int          m_state;
  logic [10:0] m_pc;
  logic [31:0] m_cnt;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0;
      m_pc    <= '0;
      m_cnt   <= '0;
    end else if (m_state == 0) begin
      if (i_start) m_state <= 1;
    end else if (m_state == 1) begin
      m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      if (mem[m_pc][15:11] == 5'd0) m_state <= 2;
      else m_pc <= 11'((int'(m_pc) + 1) % 2048);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int opc;
      logic [1:0] e_sel_a;
      logic e_sel_b, e_op, e_wr_acc, e_wr_ram, e_rd_ram;
      opc = (m_state == 1) ? int'(mem[m_pc][15:11]) : -1;
      e_wr_ram = (opc == 1);
      e_wr_acc = (opc >= 2 && opc <= 7);
      e_rd_ram = (opc == 2 || opc == 4 || opc == 6);
      e_sel_a  = (opc == 3) ? 2'd1 : (opc >= 4 && opc <= 7) ? 2'd2 : 2'd0;
      e_sel_b  = (opc == 5 || opc == 7);
      e_op     = (opc == 6 || opc == 7);
      check("addr", 32'(addr_program), 32'(m_pc));
      check("operand", 32'(o_operand), 32'(mem[m_pc][10:0]));
      check("count", o_cycle_count, m_cnt);
      check("running", 32'(o_running), 32'(m_state == 1));
      check("halted", 32'(o_halted), 32'(m_state == 2));
      check("wr_acc", 32'(o_wr_acc), 32'(e_wr_acc));
      check("wr_ram", 32'(o_wr_ram), 32'(e_wr_ram));
      check("rd_ram", 32'(o_rd_ram), 32'(e_rd_ram));
      check("sel_a", 32'(o_sel_a), 32'(e_sel_a));
      check("sel_b", 32'(o_sel_b), 32'(e_sel_b));
      check("op", 32'(o_op), 32'(e_op));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    fill(16'h0000);
    tick();
    tick();
    cmp_en = 1'b1;
    reset = 1'b0;

    // Idle after reset with no start
    for (int i = 0; i < 10; i++) tick();
    check("idle_addr", 32'(addr_program), 32'd0);
    check("idle_count", o_cycle_count, 32'd0);
    check("idle_running", 32'(o_running), 32'd0);
    check("idle_wr_acc", 32'(o_wr_acc), 32'd0);

    // LDI 5, ADDI 3, STO 10, HLT
    do_reset();
    fill(16'h0000);
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h080A; mem[3] = 16'h0000;
    start_pulse();
    check("p1_addr0", 32'(addr_program), 32'd0);
    check("p1_ldi_wr_acc", 32'(o_wr_acc), 32'd1);
    check("p1_ldi_sel_a", 32'(o_sel_a), 32'd1);
    check("p1_ldi_operand", 32'(o_operand), 32'd5);
    tick();
    check("p1_addr1", 32'(addr_program), 32'd1);
    check("p1_addi_sel_a", 32'(o_sel_a), 32'd2);
    check("p1_addi_sel_b", 32'(o_sel_b), 32'd1);
    check("p1_addi_op", 32'(o_op), 32'd0);
    tick();
    check("p1_addr2", 32'(addr_program), 32'd2);
    check("p1_sto_wr_ram", 32'(o_wr_ram), 32'd1);
    check("p1_sto_operand", 32'(o_operand), 32'd10);
    tick();
    check("p1_addr3", 32'(addr_program), 32'd3);
    check("p1_hlt_running", 32'(o_running), 32'd1);
    tick();
    check("p1_halted", 32'(o_halted), 32'd1);
    check("p1_halt_addr", 32'(addr_program), 32'd3);
    check("p1_halt_count", o_cycle_count, 32'd4);
    i_start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    i_start = 1'b0;
    check("halt_start_halted", 32'(o_halted), 32'd1);
    check("halt_start_addr", 32'(addr_program), 32'd3);
    check("halt_start_count", o_cycle_count, 32'd4);

    // SUB 7 then undefined opcode
    do_reset();
    fill(16'h0000);
    mem[0] = 16'h3007; mem[1] = 16'hF800;
    start_pulse();
    check("p2_sub_rd_ram", 32'(o_rd_ram), 32'd1);
    check("p2_sub_wr_acc", 32'(o_wr_acc), 32'd1);
    check("p2_sub_sel_a", 32'(o_sel_a), 32'd2);
    check("p2_sub_op", 32'(o_op), 32'd1);
    tick();
    check("p2_nop_addr", 32'(addr_program), 32'd1);
    check("p2_nop_wr_acc", 32'(o_wr_acc), 32'd0);
    check("p2_nop_rd_ram", 32'(o_rd_ram), 32'd0);
    tick();
    check("p2_addr2", 32'(addr_program), 32'd2);

    // PC wrap with memory full of LD 0
    do_reset();
    fill(16'h1000);
    start_pulse();
    for (int i = 0; i < 2047; i++) tick();
    check("wrap_addr2047", 32'(addr_program), 32'd2047);
    tick();
    check("wrap_addr0", 32'(addr_program), 32'd0);
    tick();
    check("wrap_addr1", 32'(addr_program), 32'd1);
    check("wrap_count", o_cycle_count, 32'd2049);

    // Reset with start while running at PC 5
    do_reset();
    fill(16'h1000);
    start_pulse();
    for (int i = 0; i < 5; i++) tick();
    check("rst_run_pc5", 32'(addr_program), 32'd5);
    reset = 1'b1;
    i_start = 1'b1;
    tick();
    reset = 1'b0;
    i_start = 1'b0;
    check("rst_running", 32'(o_running), 32'd0);
    check("rst_addr", 32'(addr_program), 32'd0);
    check("rst_count", o_cycle_count, 32'd0);
    check("rst_rd_ram", 32'(o_rd_ram), 32'd0);

    // Randomized programs, starts and resets
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 2048; i++) begin
        logic [4:0] opc;
        opc = ($urandom_range(0, 24) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mem[i] = {opc, 11'($urandom)};
      end
      for (int c = 0; c < 300; c++) begin
        i_start = ($urandom_range(0, 7) == 0);
        reset   = ($urandom_range(0, 79) == 0);
        tick();
      end
      reset = 1'b0;
      i_start = 1'b0;
    end

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Instruction fetch and decode control for the BIP I processor. Holds the program counter, drives the 11-bit address into program memory, and decodes the 16-bit instruction that comes back in the same cycle. It produces the per-cycle datapath strobes (accumulator/RAM writes, operand muxes, add/sub) and an execution-cycle counter for the debug unit. It sits between program memory (upstream) and the BIP datapath and data memory (downstream).

## Interface
- PC_WIDTH, 11, program counter / program address width
- INSTR_WIDTH, 16, instruction width; opcode = [15:11], operand = [10:0]
- OPCODE_WIDTH, 5, opcode field width
- COUNT_WIDTH, 32, execution cycle counter width

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- i_start  in  1  leave IDLE and begin execution at PC 0
- i_instruction  in  16  program memory read data for addr_program (asynchronous read)
- addr_program  out  11  current PC, drives program memory address
- o_operand  out  11  instruction[10:0], immediate value or data memory address
- o_sel_a  out  2  accumulator input mux: 00 data memory, 01 immediate, 10 ALU result
- o_sel_b  out  1  ALU B operand: 0 data memory, 1 immediate
- o_op  out  1  ALU function: 0 add, 1 sub
- o_wr_acc  out  1  accumulator write strobe
- o_wr_ram  out  1  data memory write strobe
- o_rd_ram  out  1  data memory read strobe
- o_running  out  1  state == RUN
- o_halted  out  1  state == HALT
- o_cycle_count  out  32  cycles spent in RUN

## Operation
- States: IDLE, RUN, HALT. Reset goes to IDLE.
- IDLE goes to RUN on i_start = 1. i_start is ignored in RUN and HALT.
- RUN goes to HALT when the HLT opcode is decoded. HALT is left only by reset.
- Decode is combinational from i_instruction and is active only in RUN. In IDLE and HALT all strobes, o_sel_a, o_sel_b and o_op are 0.
- Opcode decode (default for each output is 0):
  - 00000 HLT: no strobes.
  - 00001 STO: wr_ram = 1.
  - 00010 LD: rd_ram = 1, wr_acc = 1, sel_a = 00.
  - 00011 LDI: wr_acc = 1, sel_a = 01.
  - 00100 ADD: rd_ram = 1, wr_acc = 1, sel_a = 10, sel_b = 0, op = 0.
  - 00101 ADDI: wr_acc = 1, sel_a = 10, sel_b = 1, op = 0.
  - 00110 SUB: as ADD with op = 1.
  - 00111 SUBI: as ADDI with op = 1.
  - 01000–11111: undefined, executed as NOP (no strobes, PC advances).
- PC update: in RUN with a non-HLT opcode, PC = PC + 1 modulo 2^11 (2047 wraps to 0). PC holds in IDLE and HALT, and on HLT it stays at the HLT address.
- o_operand always mirrors i_instruction[10:0], in every state.
- Cycle counter: +1 on every clock edge while in RUN, including the edge that decodes HLT. Saturates at all-ones. Holds in IDLE and HALT.

## Timing
- Reset values: addr_program = 0, state = IDLE, o_cycle_count = 0, o_running = 0, o_halted = 0, all strobes and selects 0.
- Reset has priority over i_start and over any decode in the same cycle.
- addr_program is a register output. The program memory read is combinational, so i_instruction is valid in the same cycle.
- Strobes are combinational from state and i_instruction. The datapath samples them on the next rising edge, giving single-cycle execution with throughput of one instruction per clock.
- Start latency: i_start sampled at edge N puts the block in RUN after edge N. The instruction at PC 0 is decoded during cycle N+1.
- HLT at address k: at the edge after decode, state = HALT, PC = k, and the count includes that cycle.

## Test plan
- Reset, then 10 cycles with i_start = 0 -> addr_program = 0, all strobes 0, o_cycle_count = 0, o_running = 0.
- Program LDI 5 (0x1805), ADDI 3 (0x2803), STO 10 (0x080A), HLT (0x0000), then pulse i_start:
  - Addresses 0, 1, 2, 3 on consecutive cycles.
  - Strobes in order: wr_acc/sel_a = 01/operand 5; wr_acc/sel_a = 10/sel_b = 1/op = 0; wr_ram with operand 10.
  - Then o_halted = 1, addr_program = 3, o_cycle_count = 4.
- SUB 7 (0x3007) then undefined 0xF800 -> rd_ram = 1, wr_acc = 1, sel_a = 10, op = 1 on the first cycle; no strobes on the second; PC advances 0 -> 1 -> 2.
- Program fully filled with LD 0 (0x1000), run 2049 cycles -> addr_program goes 2047 -> 0 -> 1; o_cycle_count = 2049.
- In HALT, pulse i_start for 3 cycles -> state stays HALT, PC and count unchanged.
- Reset asserted together with i_start while in RUN at PC 5 -> next cycle: IDLE, addr_program = 0, count 0, strobes 0.
